// File: rtl/combin_data_stream_if.sv
`default_nettype none
// -----------------------------------------------------------------------------
// Module   : combin_data_stream_if
// Brief    : Word-in / beat-out valid-ready stream bundle for the packer.
// Revision : 1.0
// -----------------------------------------------------------------------------
interface combin_data_stream_if #(
    parameter int ISIZE = 24,
    parameter int OSIZE = 256
);
    logic                 in_valid;
    logic                 in_ready;
    logic [ISIZE-1:0]     in_data;
    logic                 in_sof;
    logic                 in_last;
    logic                 out_valid;
    logic                 out_ready;
    logic [OSIZE-1:0]     out_data;
    logic [OSIZE/8-1:0]   out_strb;
    logic                 out_last;
    logic                 err_drop;

    modport master (
        output in_valid, in_data, in_sof, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_strb, out_last, err_drop
    );

    modport slave (
        input  in_valid, in_data, in_sof, in_last, out_ready,
        output in_ready, out_valid, out_data, out_strb, out_last, err_drop
    );
endinterface
`default_nettype wire

// File: rtl/combin_data_stream.sv
`default_nettype none
// -----------------------------------------------------------------------------
// Module   : combin_data_stream
// Brief    : Packs ISIZE-bit words MSB-first into OSIZE-bit beats through a bit
//            accumulator; flushes zero-padded partial beats on line end.
// Revision : 1.0
// -----------------------------------------------------------------------------
module combin_data_stream #(
    parameter int ISIZE      = 24,
    parameter int OSIZE      = 256,
    parameter int LAST_FLUSH = 1
) (
    input  wire                  clock,
    input  wire                  rst_n,
    combin_data_stream_if.slave  stream
);

    generate
        if (ISIZE < 1 || ISIZE > OSIZE || OSIZE < 8 || (OSIZE % 8) != 0 ||
            (LAST_FLUSH != 0 && LAST_FLUSH != 1)) begin : g_bad_params
            $error("combin_data_stream: illegal ISIZE/OSIZE/LAST_FLUSH");
        end
    endgenerate

    localparam int ACC_W  = OSIZE + ISIZE;
    localparam int FILL_W = $clog2(OSIZE + ISIZE + 1);
    localparam int STRB_W = OSIZE / 8;

    localparam logic [FILL_W-1:0] c_osize      = FILL_W'(OSIZE);
    localparam logic [FILL_W-1:0] c_isize      = FILL_W'(ISIZE);
    localparam logic [FILL_W-1:0] c_fill_max   = FILL_W'(OSIZE + ISIZE - 1);
    localparam logic [FILL_W:0]   c_byte_round = (FILL_W+1)'(7);
    localparam logic              c_last_flush = (LAST_FLUSH != 0);

    logic [ACC_W-1:0]   r_acc;
    logic [FILL_W-1:0]  r_fill;
    logic               r_flush_pend;
    logic [OSIZE-1:0]   r_out_data;
    logic [STRB_W-1:0]  r_out_strb;
    logic               r_out_last;
    logic               r_out_valid;
    logic               r_err_drop;

    logic               w_can_load;
    logic               w_in_ready;
    logic               w_accept;
    logic               w_drain;
    logic               w_flush_beat;
    logic               w_drop_nz;
    logic [FILL_W-1:0]  w_drained;
    logic [FILL_W-1:0]  w_fill_drained;
    logic [FILL_W-1:0]  w_fill_base;
    logic [FILL_W-1:0]  w_fill_next;
    logic [ACC_W-1:0]   w_acc_drained;
    logic [ACC_W-1:0]   w_acc_base;
    logic [ACC_W-1:0]   w_word_aligned;
    logic [ACC_W-1:0]   w_acc_next;
    logic [OSIZE-1:0]   w_beat_mask;
    logic [OSIZE-1:0]   w_beat_data;
    logic [FILL_W:0]    w_strb_bytes;
    logic [STRB_W-1:0]  w_beat_strb;

    always_comb begin
        w_can_load   = !r_out_valid || stream.out_ready;
        w_in_ready   = rst_n && !r_flush_pend && ((r_fill < c_osize) || w_can_load);
        w_accept     = stream.in_valid && w_in_ready;
        w_drain      = w_can_load &&
                       ((r_fill >= c_osize) || (r_flush_pend && (r_fill != '0)));
        w_flush_beat = w_drain && r_flush_pend && (r_fill <= c_osize);
        w_drained    = (r_fill >= c_osize) ? c_osize : r_fill;

        if (w_drain) begin
            w_acc_drained  = r_acc << OSIZE;
            w_fill_drained = r_fill - w_drained;
        end else begin
            w_acc_drained  = r_acc;
            w_fill_drained = r_fill;
        end

        // Start-of-frame drops whatever is left after this cycle's drain;
        // the beat being drained right now is still delivered.
        w_drop_nz = w_accept && stream.in_sof && (w_acc_drained != '0);
        if (w_accept && stream.in_sof) begin
            w_acc_base  = '0;
            w_fill_base = '0;
        end else begin
            w_acc_base  = w_acc_drained;
            w_fill_base = w_fill_drained;
        end

        w_word_aligned = {stream.in_data, {OSIZE{1'b0}}} >> w_fill_base;

        if (w_accept) begin
            w_acc_next  = w_acc_base | w_word_aligned;
            w_fill_next = w_fill_base + c_isize;
        end else begin
            w_acc_next  = w_acc_drained;
            w_fill_next = w_fill_drained;
        end
    end

    // Flush beats keep only the top r_fill bits and ceil(r_fill/8) strobes.
    always_comb begin
        w_strb_bytes = ({1'b0, r_fill} + c_byte_round) >> 3;
        if (w_flush_beat) begin
            w_beat_mask = ~({OSIZE{1'b1}} >> r_fill);
            w_beat_strb = ~({STRB_W{1'b1}} >> w_strb_bytes);
        end else begin
            w_beat_mask = {OSIZE{1'b1}};
            w_beat_strb = {STRB_W{1'b1}};
        end
        w_beat_data = r_acc[ACC_W-1 -: OSIZE] & w_beat_mask;
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            r_acc        <= '0;
            r_fill       <= '0;
            r_flush_pend <= 1'b0;
            r_out_data   <= '0;
            r_out_strb   <= '0;
            r_out_last   <= 1'b0;
            r_out_valid  <= 1'b0;
            r_err_drop   <= 1'b0;
        end else begin
            r_acc      <= w_acc_next;
            r_fill     <= w_fill_next;
            r_err_drop <= w_drop_nz;

            if (w_flush_beat) begin
                r_flush_pend <= 1'b0;
            end else if (w_accept && stream.in_last && c_last_flush) begin
                r_flush_pend <= 1'b1;
            end

            if (w_drain) begin
                r_out_data  <= w_beat_data;
                r_out_strb  <= w_beat_strb;
                r_out_last  <= w_flush_beat;
                r_out_valid <= 1'b1;
            end else if (stream.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign stream.in_ready  = w_in_ready;
    assign stream.out_valid = r_out_valid;
    assign stream.out_data  = r_out_data;
    assign stream.out_strb  = r_out_strb;
    assign stream.out_last  = r_out_last;
    assign stream.err_drop  = r_err_drop;

`ifndef SYNTHESIS
    always_ff @(posedge clock) begin
        if (rst_n) begin
            assert (r_fill <= c_fill_max);
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_combin_data_stream.sv
`default_nettype none
// Bench for combin_data_stream: two instances (24->256 and 32->64) checked
// against a bit-queue packing model.
module tb_combin_data_stream;

    logic clock = 1'b0;
    logic rst_n = 1'b0;
    always #5 clock = ~clock;

    logic tb_ready = 1'b1;

    combin_data_stream_if #(.ISIZE(24), .OSIZE(256)) if_a ();
    combin_data_stream_if #(.ISIZE(32), .OSIZE(64))  if_b ();

    assign if_a.out_ready = tb_ready;
    assign if_b.out_ready = tb_ready;

    combin_data_stream #(.ISIZE(24), .OSIZE(256), .LAST_FLUSH(1)) u_dut_a (
        .clock (clock),
        .rst_n (rst_n),
        .stream(if_a.slave)
    );

    combin_data_stream #(.ISIZE(32), .OSIZE(64), .LAST_FLUSH(1)) u_dut_b (
        .clock (clock),
        .rst_n (rst_n),
        .stream(if_b.slave)
    );

    int tests_run    = 0;
    int tests_failed = 0;
    bit sel          = 1'b0;
    bit rand_mode    = 1'b0;
    int stall_cycles = 0;
    int timeouts     = 0;
    int stall_viol   = 0;
    int obs_err      = 0;
    int exp_err      = 0;

    logic         m_in_ready, m_out_valid, m_out_ready, m_out_last, m_err;
    logic [255:0] m_out_data;
    logic [31:0]  m_out_strb;

    always_comb begin
        m_out_ready = tb_ready;
        if (sel) begin
            m_in_ready  = if_b.in_ready;
            m_out_valid = if_b.out_valid;
            m_out_last  = if_b.out_last;
            m_err       = if_b.err_drop;
            m_out_data  = {192'b0, if_b.out_data};
            m_out_strb  = {24'b0, if_b.out_strb};
        end else begin
            m_in_ready  = if_a.in_ready;
            m_out_valid = if_a.out_valid;
            m_out_last  = if_a.out_last;
            m_err       = if_a.err_drop;
            m_out_data  = if_a.out_data;
            m_out_strb  = if_a.out_strb;
        end
    end

    logic [255:0] obs_data[$];
    logic [31:0]  obs_strb[$];
    bit           obs_last[$];
    logic [255:0] exp_data[$];
    logic [31:0]  exp_strb[$];
    bit           exp_last[$];
    bit           pend[$];

    bit           held = 1'b0;
    logic [255:0] held_data;
    logic [31:0]  held_strb;
    logic         held_last;

    // Beat capture and hold-stability observation, sampled mid-cycle.
    always @(negedge clock) begin
        if (!rst_n) begin
            held = 1'b0;
        end else begin
            if (held && (!m_out_valid || m_out_data !== held_data ||
                         m_out_strb !== held_strb || m_out_last !== held_last))
                stall_viol++;
            held      = m_out_valid && !m_out_ready;
            held_data = m_out_data;
            held_strb = m_out_strb;
            held_last = m_out_last;
            if (m_out_valid && m_out_ready) begin
                obs_data.push_back(m_out_data);
                obs_strb.push_back(m_out_strb);
                obs_last.push_back(m_out_last);
            end
            if (m_err) obs_err++;
        end
    end

    // ---------------- reference model ----------------
    task automatic emit(input int n, input bit last, input int osz);
        logic [255:0] d;
        logic [31:0]  s;
        d = '0;
        s = '0;
        for (int i = 0; i < n; i++) d[osz-1-i] = pend.pop_front();
        if (last) for (int b = 0; b < (n + 7) / 8; b++) s[osz/8-1-b] = 1'b1;
        else      for (int b = 0; b < osz / 8; b++)     s[b] = 1'b1;
        exp_data.push_back(d);
        exp_strb.push_back(s);
        exp_last.push_back(last);
    endtask

    task automatic model_push(input logic [31:0] data, input bit sof, input bit last);
        int isz;
        int osz;
        bit nz;
        isz = sel ? 32 : 24;
        osz = sel ? 64 : 256;
        if (sof) begin
            nz = 1'b0;
            foreach (pend[i]) if (pend[i]) nz = 1'b1;
            if (nz) exp_err++;
            pend.delete();
        end
        for (int i = isz - 1; i >= 0; i--) pend.push_back(data[i]);
        if (last) begin
            while (pend.size() > osz) emit(osz, 1'b0, osz);
            emit(pend.size(), 1'b1, osz);
        end else begin
            while (pend.size() >= osz) emit(osz, 1'b0, osz);
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clock);
        #1;
        if (rand_mode) tb_ready = ($urandom_range(0, 99) < 30);
    endtask

    task automatic set_in(input bit v, input logic [31:0] d, input bit sof, input bit last);
        if (sel) begin
            if_b.in_valid = v; if_b.in_data = d; if_b.in_sof = sof; if_b.in_last = last;
        end else begin
            if_a.in_valid = v; if_a.in_data = d[23:0]; if_a.in_sof = sof; if_a.in_last = last;
        end
    endtask

    task automatic drive_word(input logic [31:0] d, input bit sof, input bit last);
        bit accepted;
        accepted = 1'b0;
        set_in(1'b1, d, sof, last);
        for (int c = 0; c < 400 && !accepted; c++) begin
            @(negedge clock);
            if (m_in_ready) begin
                model_push(d, sof, last);
                accepted = 1'b1;
            end else begin
                stall_cycles++;
            end
            step();
        end
        if (!accepted) timeouts++;
        set_in(1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic wait_drain(input int budget);
        for (int c = 0; c < budget && obs_data.size() < exp_data.size(); c++) step();
        repeat (6) step();
    endtask

    task automatic clear_sb();
        obs_data.delete(); obs_strb.delete(); obs_last.delete();
        exp_data.delete(); exp_strb.delete(); exp_last.delete();
        pend.delete();
        exp_err = 0; obs_err = 0; stall_cycles = 0; timeouts = 0; stall_viol = 0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        rst_n = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        tests_run++; if (if_a.out_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_out_valid: got %b expected 0", if_a.out_valid); end
        tests_run++; if (if_a.out_data !== 256'h0) begin tests_failed++; $display("FAIL rst_out_data: got %h expected 0", if_a.out_data); end
        tests_run++; if (if_a.out_strb !== 32'h0) begin tests_failed++; $display("FAIL rst_out_strb: got %h expected 0", if_a.out_strb); end
        tests_run++; if (if_a.out_last !== 1'b0) begin tests_failed++; $display("FAIL rst_out_last: got %b expected 0", if_a.out_last); end
        tests_run++; if (if_a.err_drop !== 1'b0) begin tests_failed++; $display("FAIL rst_err_drop: got %b expected 0", if_a.err_drop); end
        tests_run++; if (if_a.in_ready !== 1'b0) begin tests_failed++; $display("FAIL rst_in_ready: got %b expected 0", if_a.in_ready); end
        tests_run++; if (if_b.out_valid !== 1'b0 || if_b.in_ready !== 1'b0) begin tests_failed++; $display("FAIL rst_b_outputs: got valid=%b ready=%b expected 0 0", if_b.out_valid, if_b.in_ready); end
        @(posedge clock);
        #1;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_back_to_back();
        sel = 1'b0; tb_ready = 1'b1; clear_sb();
        for (int i = 1; i <= 32; i++) drive_word(32'(i), 1'b0, 1'b0);
        wait_drain(60);
        tests_run++; if (stall_cycles != 0) begin tests_failed++; $display("FAIL b2b_in_ready_low: got %0d cycles expected 0", stall_cycles); end
        tests_run++; if (obs_data.size() != 3) begin tests_failed++; $display("FAIL b2b_beat_count: got %0d expected 3", obs_data.size()); end
        if (obs_data.size() == 3) begin
            tests_run++; if (obs_data[0][255:232] !== 24'h000001) begin tests_failed++; $display("FAIL b2b_first_word: got %h expected 000001", obs_data[0][255:232]); end
            tests_run++; if (obs_data[2][23:0] !== 24'h000020) begin tests_failed++; $display("FAIL b2b_last_word: got %h expected 000020", obs_data[2][23:0]); end
        end
        for (int i = 0; i < obs_data.size() && i < exp_data.size(); i++) begin
            tests_run++;
            if (obs_data[i] !== exp_data[i] || obs_strb[i] !== exp_strb[i] || obs_last[i] !== exp_last[i]) begin
                tests_failed++;
                $display("FAIL b2b_beat%0d: got %h/%h/%0b expected %h/%h/%0b", i, obs_data[i], obs_strb[i], obs_last[i], exp_data[i], exp_strb[i], exp_last[i]);
            end
        end
        tests_run++; if (u_dut_a.r_fill !== '0) begin tests_failed++; $display("FAIL b2b_fill_zero: got %0d expected 0", u_dut_a.r_fill); end
    endtask

    task automatic test_line_flush();
        logic [31:0] w;
        int early;
        int seen_at;
        sel = 1'b0; tb_ready = 1'b1; clear_sb();
        w = 32'h0; early = 0; seen_at = -1;
        for (int i = 0; i < 11; i++) begin
            w = $urandom & 32'h00FF_FFFF;
            drive_word(w, 1'b0, i == 10);
        end
        for (int c = 0; c < 10 && seen_at < 0; c++) begin
            @(negedge clock);
            if (m_out_valid && m_out_last) begin
                seen_at = c;
                tests_run++; if (m_in_ready !== 1'b1) begin tests_failed++; $display("FAIL flush_ready_after: got %b expected 1", m_in_ready); end
            end else if (m_in_ready) begin
                early++;
            end
        end
        step();
        tests_run++; if (early != 0) begin tests_failed++; $display("FAIL flush_ready_blocked: got %0d ready cycles expected 0", early); end
        tests_run++; if (seen_at != 2) begin tests_failed++; $display("FAIL flush_latency: got %0d expected 2", seen_at); end
        wait_drain(30);
        tests_run++; if (obs_data.size() != 2) begin tests_failed++; $display("FAIL flush_beat_count: got %0d expected 2", obs_data.size()); end
        if (obs_data.size() == 2) begin
            tests_run++; if (obs_last[0] !== 1'b0 || obs_last[1] !== 1'b1) begin tests_failed++; $display("FAIL flush_last_flags: got %0b%0b expected 01", obs_last[0], obs_last[1]); end
            tests_run++; if (obs_strb[1] !== 32'h8000_0000) begin tests_failed++; $display("FAIL flush_strb: got %h expected 80000000", obs_strb[1]); end
            tests_run++; if (obs_data[1][255:248] !== w[7:0]) begin tests_failed++; $display("FAIL flush_tail_byte: got %h expected %h", obs_data[1][255:248], w[7:0]); end
            tests_run++; if (obs_data[1][247:0] !== 248'h0) begin tests_failed++; $display("FAIL flush_padding: got %h expected 0", obs_data[1][247:0]); end
        end
        for (int i = 0; i < obs_data.size() && i < exp_data.size(); i++) begin
            tests_run++;
            if (obs_data[i] !== exp_data[i] || obs_strb[i] !== exp_strb[i] || obs_last[i] !== exp_last[i]) begin
                tests_failed++;
                $display("FAIL flush_beat%0d: got %h/%h/%0b expected %h/%h/%0b", i, obs_data[i], obs_strb[i], obs_last[i], exp_data[i], exp_strb[i], exp_last[i]);
            end
        end
    endtask

    task automatic test_small_ratio();
        sel = 1'b1; tb_ready = 1'b1; clear_sb();
        for (int i = 0; i < 4; i++) drive_word($urandom, 1'b0, i == 3);
        wait_drain(30);
        repeat (5) step();
        tests_run++; if (obs_data.size() != 2) begin tests_failed++; $display("FAIL small_beat_count: got %0d expected 2", obs_data.size()); end
        if (obs_data.size() == 2) begin
            tests_run++; if (obs_last[1] !== 1'b1 || obs_strb[1] !== 32'h0000_00FF) begin tests_failed++; $display("FAIL small_final: got last=%0b strb=%h expected 1 ff", obs_last[1], obs_strb[1]); end
            tests_run++; if (obs_last[0] !== 1'b0) begin tests_failed++; $display("FAIL small_first_last: got %0b expected 0", obs_last[0]); end
        end
        for (int i = 0; i < obs_data.size() && i < exp_data.size(); i++) begin
            tests_run++;
            if (obs_data[i] !== exp_data[i] || obs_strb[i] !== exp_strb[i] || obs_last[i] !== exp_last[i]) begin
                tests_failed++;
                $display("FAIL small_beat%0d: got %h/%h/%0b expected %h/%h/%0b", i, obs_data[i], obs_strb[i], obs_last[i], exp_data[i], exp_strb[i], exp_last[i]);
            end
        end
        sel = 1'b0;
    endtask

    task automatic test_random_backpressure();
        sel = 1'b0; clear_sb(); rand_mode = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 4) == 0) step();
            drive_word($urandom, 1'b0, (i == 199) || ($urandom_range(0, 11) == 0));
        end
        wait_drain(4000);
        rand_mode = 1'b0; tb_ready = 1'b1;
        repeat (4) step();
        tests_run++; if (timeouts != 0) begin tests_failed++; $display("FAIL rand_timeouts: got %0d expected 0", timeouts); end
        tests_run++; if (stall_viol != 0) begin tests_failed++; $display("FAIL rand_hold_stable: got %0d violations expected 0", stall_viol); end
        tests_run++; if (obs_data.size() != exp_data.size()) begin tests_failed++; $display("FAIL rand_beat_count: got %0d expected %0d", obs_data.size(), exp_data.size()); end
        for (int i = 0; i < obs_data.size() && i < exp_data.size(); i++) begin
            tests_run++;
            if (obs_data[i] !== exp_data[i] || obs_strb[i] !== exp_strb[i] || obs_last[i] !== exp_last[i]) begin
                tests_failed++;
                $display("FAIL rand_beat%0d: got %h/%h/%0b expected %h/%h/%0b", i, obs_data[i], obs_strb[i], obs_last[i], exp_data[i], exp_strb[i], exp_last[i]);
            end
        end
        tests_run++; if (u_dut_a.r_fill !== '0) begin tests_failed++; $display("FAIL rand_fill_zero: got %0d expected 0", u_dut_a.r_fill); end
    endtask

    task automatic test_sof_drop();
        logic [31:0] s;
        sel = 1'b0; tb_ready = 1'b1;
        apply_reset();
        clear_sb();
        drive_word($urandom | 32'h1, 1'b1, 1'b0);
        @(negedge clock);
        tests_run++; if (m_err !== 1'b0) begin tests_failed++; $display("FAIL sof_first_err: got %b expected 0", m_err); end
        step();
        for (int i = 0; i < 4; i++) drive_word($urandom | 32'h1, 1'b0, 1'b0);
        s = $urandom | 32'h0080_0000;
        drive_word(s, 1'b1, 1'b0);
        @(negedge clock);
        tests_run++; if (m_err !== 1'b1) begin tests_failed++; $display("FAIL sof_err_pulse: got %b expected 1", m_err); end
        step();
        @(negedge clock);
        tests_run++; if (m_err !== 1'b0) begin tests_failed++; $display("FAIL sof_err_width: got %b expected 0", m_err); end
        step();
        for (int i = 0; i < 10; i++) drive_word($urandom, 1'b0, 1'b0);
        wait_drain(30);
        tests_run++; if (obs_err != 1 || exp_err != 1) begin tests_failed++; $display("FAIL sof_err_count: got %0d expected %0d", obs_err, exp_err); end
        tests_run++; if (obs_data.size() != 1) begin tests_failed++; $display("FAIL sof_beat_count: got %0d expected 1", obs_data.size()); end
        if (obs_data.size() >= 1) begin
            tests_run++; if (obs_data[0][255:232] !== s[23:0]) begin tests_failed++; $display("FAIL sof_word_msb: got %h expected %h", obs_data[0][255:232], s[23:0]); end
        end
        for (int i = 0; i < obs_data.size() && i < exp_data.size(); i++) begin
            tests_run++;
            if (obs_data[i] !== exp_data[i] || obs_strb[i] !== exp_strb[i] || obs_last[i] !== exp_last[i]) begin
                tests_failed++;
                $display("FAIL sof_beat%0d: got %h/%h/%0b expected %h/%h/%0b", i, obs_data[i], obs_strb[i], obs_last[i], exp_data[i], exp_strb[i], exp_last[i]);
            end
        end
    endtask

    task automatic test_reset_mid_flush();
        sel = 1'b0;
        apply_reset();
        clear_sb();
        tb_ready = 1'b0;
        for (int i = 0; i < 11; i++) drive_word($urandom, 1'b0, i == 10);
        repeat (3) step();
        @(negedge clock);
        tests_run++; if (m_out_valid !== 1'b1 || u_dut_a.r_flush_pend !== 1'b1) begin tests_failed++; $display("FAIL midrst_precondition: got valid=%b pend=%b expected 1 1", m_out_valid, u_dut_a.r_flush_pend); end
        @(posedge clock);
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++; if (if_a.out_valid !== 1'b0 || if_a.out_last !== 1'b0) begin tests_failed++; $display("FAIL midrst_async_valid: got valid=%b last=%b expected 0 0", if_a.out_valid, if_a.out_last); end
        tests_run++; if (if_a.out_data !== 256'h0 || if_a.out_strb !== 32'h0) begin tests_failed++; $display("FAIL midrst_async_data: got %h/%h expected 0/0", if_a.out_data, if_a.out_strb); end
        tests_run++; if (if_a.in_ready !== 1'b0) begin tests_failed++; $display("FAIL midrst_in_ready: got %b expected 0", if_a.in_ready); end
        @(posedge clock);
        #1;
        rst_n = 1'b1;
        clear_sb();
        tb_ready = 1'b1;
        repeat (10) step();
        tests_run++; if (obs_data.size() != 0) begin tests_failed++; $display("FAIL midrst_no_beat: got %0d beats expected 0", obs_data.size()); end
        for (int i = 0; i < 11; i++) drive_word($urandom, 1'b0, 1'b0);
        wait_drain(30);
        tests_run++; if (obs_data.size() != 1) begin tests_failed++; $display("FAIL midrst_beat_count: got %0d expected 1", obs_data.size()); end
        for (int i = 0; i < obs_data.size() && i < exp_data.size(); i++) begin
            tests_run++;
            if (obs_data[i] !== exp_data[i] || obs_strb[i] !== exp_strb[i] || obs_last[i] !== exp_last[i]) begin
                tests_failed++;
                $display("FAIL midrst_beat%0d: got %h/%h/%0b expected %h/%h/%0b", i, obs_data[i], obs_strb[i], obs_last[i], exp_data[i], exp_strb[i], exp_last[i]);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        if_a.in_valid = 1'b0; if_a.in_data = '0; if_a.in_sof = 1'b0; if_a.in_last = 1'b0;
        if_b.in_valid = 1'b0; if_b.in_data = '0; if_b.in_sof = 1'b0; if_b.in_last = 1'b0;
        test_reset();
        test_back_to_back();
        test_line_flush();
        test_small_ratio();
        test_random_backpressure();
        test_sof_drop();
        test_reset_mid_flush();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire
